pcie_descrambler_mlane: RTL and testbench

PCIE_DESCRAMBLER_MLANE -- requirements
Module: pcie_descrambler_mlane

---
 rtl/pcie_scramble_pkg.sv | 41 ++++
 rtl/pcie_lfsr_advance.sv | 26 ++
 rtl/pcie_descrambler_mlane.sv | 127 ++++++++++++
 tb/tb_pcie_descrambler_mlane.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_scramble_pkg.sv
// Shared constants for the 128b/130b lane descrambler: LFSR geometry, taps, per-lane seeds,
// and the block classification used to decide bypass and LFSR update.
package pcie_scramble_pkg;

    localparam int LFSR_WIDTH = 23;

    // x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form: feedback from bit 22 into bits 21,16,8,5,2,0
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 23'h210125;

    typedef enum logic [1:0] {
        BLK_DATA,
        BLK_CTL,
        BLK_SKP,
        BLK_RESEED
    } blk_class_t;

    function automatic logic [LFSR_WIDTH-1:0] lane_seed(input int unsigned lane);
        logic [LFSR_WIDTH-1:0] seed;
        case (lane % 8)
            0:       seed = 23'h1DBFBC;
            1:       seed = 23'h0607BB;
            2:       seed = 23'h1EC760;
            3:       seed = 23'h18C0DB;
            4:       seed = 23'h010F12;
            5:       seed = 23'h19CFC9;
            6:       seed = 23'h0277CE;
            default: seed = 23'h1BB807;
        endcase
        return seed;
    endfunction

    function automatic blk_class_t classify(input logic is_ctl, input logic is_skp, input logic reseed);
        blk_class_t cls;
        if (reseed)      cls = BLK_RESEED;
        else if (is_skp) cls = BLK_SKP;
        else if (is_ctl) cls = BLK_CTL;
        else             cls = BLK_DATA;
        return cls;
    endfunction

endpackage

// File: rtl/pcie_lfsr_advance.sv
// Combinational N-step LFSR walk: emits N keystream bits (bit 0 first) and the advanced state.
// No latency, no flow control.
module pcie_lfsr_advance #(
    parameter int N          = 32,
    parameter int LFSR_WIDTH = 23
) (
    input  logic [LFSR_WIDTH-1:0] state_i,
    output logic [N-1:0]          keystream_o,
    output logic [LFSR_WIDTH-1:0] state_o
);
    import pcie_scramble_pkg::*;

    logic [LFSR_WIDTH-1:0] walk;

    always_comb begin
        walk        = state_i;
        keystream_o = '0;
        for (int i = 0; i < N; i++) begin
            keystream_o[i] = walk[LFSR_WIDTH-1];
            walk = {walk[LFSR_WIDTH-2:0], 1'b0}
                 ^ (walk[LFSR_WIDTH-1] ? LFSR_WIDTH'(LFSR_TAPS) : '0);
        end
        state_o = walk;
    end

endmodule

// File: rtl/pcie_descrambler_mlane.sv
// Multi-lane PCIe block descrambler, one SCRAMBLE_WIDTH chunk per pipeline stage.
// Latency STAGES cycles after accept; out_valid && !out_ready freezes everything and drops in_ready.
module pcie_descrambler_mlane #(
    parameter int NUM_LANES      = 4,
    parameter int DW             = 128,
    parameter int SCRAMBLE_WIDTH = 32,
    parameter int LFSR_WIDTH     = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_LANES*DW-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_is_ctl,
    input  logic                    in_is_skp,
    input  logic                    in_reseed,
    input  logic                    descramble_enable,
    output logic [NUM_LANES*DW-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_ctl
);
    import pcie_scramble_pkg::*;

    localparam int STAGES = DW / SCRAMBLE_WIDTH;
    localparam int BW     = NUM_LANES * DW;

    logic       stall;
    logic       accept;
    blk_class_t in_cls;

    logic [NUM_LANES-1:0][LFSR_WIDTH-1:0] lane_q, lane_d, lane_adv;
    logic [NUM_LANES-1:0][DW-1:0]         lane_ks_unused;

    logic [STAGES-1:0]                                    st_vld_q, st_byp_q, st_ctl_q;
    logic [STAGES-1:0][BW-1:0]                            st_data_q, st_data_x;
    logic [STAGES-1:0][NUM_LANES-1:0][LFSR_WIDTH-1:0]     st_lfsr_q, st_lfsr_nxt;
    logic [STAGES-1:0][NUM_LANES-1:0][SCRAMBLE_WIDTH-1:0] st_ks;
    logic [NUM_LANES-1:0][LFSR_WIDTH-1:0]                 last_lfsr_unused;

    logic          out_valid_q;
    logic [BW-1:0] out_data_q;
    logic          out_is_ctl_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign in_cls   = classify(in_is_ctl, in_is_skp, in_reseed);

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_is_ctl = out_is_ctl_q;

    // Whole-block advance keeps the lane state one block ahead so back-to-back accepts work.
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        pcie_lfsr_advance #(.N(DW), .LFSR_WIDTH(LFSR_WIDTH)) u_lane_adv (
            .state_i     (lane_q[n]),
            .keystream_o (lane_ks_unused[n]),
            .state_o     (lane_adv[n])
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
            pcie_lfsr_advance #(.N(SCRAMBLE_WIDTH), .LFSR_WIDTH(LFSR_WIDTH)) u_stage_adv (
                .state_i     (st_lfsr_q[k][n]),
                .keystream_o (st_ks[k][n]),
                .state_o     (st_lfsr_nxt[k][n])
            );
            assign st_data_x[k][n*DW +: DW] = st_data_q[k][n*DW +: DW]
                ^ (st_byp_q[k] ? '0 : (DW'(st_ks[k][n]) << (k*SCRAMBLE_WIDTH)));
        end
    end

    assign last_lfsr_unused = st_lfsr_nxt[STAGES-1];

    always_comb begin
        lane_d = lane_q;
        if (accept && descramble_enable) begin
            unique case (in_cls)
                BLK_DATA, BLK_CTL: lane_d = lane_adv;
                BLK_RESEED: begin
                    for (int n = 0; n < NUM_LANES; n++) lane_d[n] = LFSR_WIDTH'(lane_seed(n));
                end
                default: lane_d = lane_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_LANES; n++) lane_q[n] <= LFSR_WIDTH'(lane_seed(n));
            st_vld_q     <= '0;
            st_byp_q     <= '0;
            st_ctl_q     <= '0;
            st_data_q    <= '0;
            st_lfsr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_is_ctl_q <= 1'b1;
        end else if (!stall) begin
            lane_q      <= lane_d;
            st_vld_q[0] <= accept;
            if (accept) begin
                st_data_q[0] <= in_data;
                st_lfsr_q[0] <= lane_q;
                st_byp_q[0]  <= !(descramble_enable && in_cls == BLK_DATA);
                st_ctl_q[0]  <= in_is_ctl | in_is_skp | in_reseed;
            end
            for (int k = 1; k < STAGES; k++) begin
                st_vld_q[k] <= st_vld_q[k-1];
                if (st_vld_q[k-1]) begin
                    st_data_q[k] <= st_data_x[k-1];
                    st_lfsr_q[k] <= st_lfsr_nxt[k-1];
                    st_byp_q[k]  <= st_byp_q[k-1];
                    st_ctl_q[k]  <= st_ctl_q[k-1];
                end
            end
            out_valid_q <= st_vld_q[STAGES-1];
            if (st_vld_q[STAGES-1]) begin
                out_data_q   <= st_data_x[STAGES-1];
                out_is_ctl_q <= st_ctl_q[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_pcie_descrambler_mlane.sv
// Bench for pcie_descrambler_mlane: keystream-position model with an in-order scoreboard,
// plus literal first-byte pins per lane seed.
module tb_pcie_descrambler_mlane;

    localparam int NL     = 4;
    localparam int DW     = 128;
    localparam int SW     = 32;
    localparam int LW     = 23;
    localparam int ST     = DW / SW;
    localparam int TW     = NL * DW;
    localparam int KS_LEN = 16384;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_is_ctl = 1'b0;
    logic          in_is_skp = 1'b0;
    logic          in_reseed = 1'b0;
    logic          descramble_enable = 1'b1;
    logic [TW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_is_ctl;

    always #5 clk = ~clk;

    pcie_descrambler_mlane #(
        .NUM_LANES(NL), .DW(DW), .SCRAMBLE_WIDTH(SW), .LFSR_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_ctl(in_is_ctl), .in_is_skp(in_is_skp), .in_reseed(in_reseed),
        .descramble_enable(descramble_enable),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_is_ctl(out_is_ctl)
    );

    // Keystream per lane indexed by bit position since seeding.
    bit            ks [NL][KS_LEN];
    int            pos [NL];
    int            spos [NL];
    logic [TW-1:0] exp_q [$];
    logic          exp_ctl_q [$];
    logic [TW-1:0] out_log [$];
    logic          out_ctl_log [$];
    logic [TW-1:0] plain_q [$];
    int            tests = 0;
    int            fails = 0;
    bit            pre_acc = 1'b0;
    bit            cnt_rdy_en = 1'b0;
    int            rdy_low = 0;
    logic [TW-1:0] e_tmp;
    logic          c_tmp;

    logic [22:0] seeds [8] = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
                               23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
    logic [7:0]  pins  [4] = '{8'h6C, 8'hF0, 8'h8C, 8'h7C};

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_blk();
        logic [TW-1:0] r;
        for (int w = 0; w < TW/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Output bit t of the Galois LFSR: seed bit 22-t plus feedback echoes at tap distances.
    task automatic build_keystream();
        int dl [6] = '{2, 7, 15, 18, 21, 23};
        for (int n = 0; n < NL; n++) begin
            logic [22:0] sd;
            sd = seeds[n % 8];
            for (int t = 0; t < KS_LEN; t++) begin
                bit b;
                b = (t <= 22) ? sd[22-t] : 1'b0;
                for (int j = 0; j < 6; j++)
                    if (t >= dl[j]) b ^= ks[n][t-dl[j]];
                ks[n][t] = b;
            end
        end
    endtask

    task automatic model_accept();
        e_tmp = in_data;
        if (descramble_enable) begin
            if (in_reseed) begin
                for (int n = 0; n < NL; n++) pos[n] = 0;
            end else if (in_is_skp) begin
            end else begin
                if (pos[0] + DW > KS_LEN) begin
                    $display("FAIL model_range actual=%0d required<=%0d", pos[0] + DW, KS_LEN);
                    $fatal(1);
                end
                if (!in_is_ctl)
                    for (int n = 0; n < NL; n++)
                        for (int i = 0; i < DW; i++)
                            e_tmp[n*DW + i] ^= ks[n][pos[n] + i];
                for (int n = 0; n < NL; n++) pos[n] += DW;
            end
        end
        exp_q.push_back(e_tmp);
        exp_ctl_q.push_back(in_is_ctl | in_is_skp | in_reseed);
    endtask

    // Sample one time unit before each rising edge: exactly what the DUT sees at that edge.
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            exp_q.delete();
            exp_ctl_q.delete();
            for (int n = 0; n < NL; n++) pos[n] = 0;
            pre_acc = 1'b0;
        end else begin
            pre_acc = in_valid && in_ready;
            if (cnt_rdy_en && !in_ready) rdy_low++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected actual=%0h required=none", out_data);
                end else begin
                    e_tmp = exp_q.pop_front();
                    c_tmp = exp_ctl_q.pop_front();
                    check("sb_data", out_data, e_tmp);
                    check("sb_ctl", TW'(out_is_ctl), TW'(c_tmp));
                end
                out_log.push_back(out_data);
                out_ctl_log.push_back(out_is_ctl);
            end
            if (pre_acc) model_accept();
        end
    end

    task automatic send(input logic [TW-1:0] d, input logic c, input logic s,
                        input logic r, input logic e);
        int t;
        in_data = d; in_is_ctl = c; in_is_skp = s; in_reseed = r;
        descramble_enable = e; in_valid = 1'b1;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!pre_acc && t < 200);
        #1;
        in_valid = 1'b0;
        check("send_accept", TW'(pre_acc), TW'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1; t++;
        end
        check("drain", TW'(exp_q.size()), TW'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_pins(input string name, input logic [TW-1:0] o);
        for (int n = 0; n < NL; n++)
            check(name, TW'(o[n*DW +: 8]), TW'(pins[n]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base, lat, t;
        logic [TW-1:0] d1, d2, sk, o_a, p, s;
        logic [7:0] byte_v;
        bit done;

        build_keystream();
        for (int n = 0; n < NL; n++) begin
            for (int i = 0; i < 8; i++) byte_v[i] = ks[n][i];
            check("model_pin", TW'(byte_v), TW'(pins[n]));
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", TW'(out_valid), TW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_is_ctl", TW'(out_is_ctl), TW'(1));
        check("rst_in_ready", TW'(in_ready), TW'(1));
        rst_n = 1'b1;

        // Reset mid-stream discards in-flight blocks
        send(rand_blk(), 1'b0, 1'b0, 1'b0, 1'b1);
        send(rand_blk(), 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        check("midrst_out_valid", TW'(out_valid), TW'(0));

        // Zero block from seeds, latency
        base = out_log.size();
        send('0, 1'b0, 1'b0, 1'b0, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", TW'(lat), TW'(ST));
        drain();
        check_pins("seed_pin", out_log[base]);

        // Control block passes unchanged, following data block uses advanced state
        do_reset();
        base = out_log.size();
        send({64{8'hA5}}, 1'b1, 1'b0, 1'b0, 1'b1);
        send('0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check("ctl_passthru", out_log[base], {64{8'hA5}});
        check("ctl_flag", TW'(out_ctl_log[base]), TW'(1));
        check("data_flag", TW'(out_ctl_log[base+1]), TW'(0));

        // SKP is transparent to the keystream
        d1 = rand_blk(); d2 = rand_blk(); sk = rand_blk();
        do_reset();
        base = out_log.size();
        send(d1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(sk, 1'b0, 1'b1, 1'b0, 1'b1);
        send(d2, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        o_a = out_log[base+2];
        do_reset();
        base = out_log.size();
        send(d1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(d2, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check("skp_transparent", out_log[base+1], o_a);

        // Reseed restarts each lane at its seed
        base = out_log.size();
        send(rand_blk(), 1'b0, 1'b0, 1'b0, 1'b1);
        send(rand_blk(), 1'b0, 1'b0, 1'b1, 1'b1);
        send('0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check_pins("reseed_pin", out_log[base+2]);

        // Six back-to-back blocks with a three-cycle output stall
        base = out_log.size();
        rdy_low = 0;
        cnt_rdy_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_blk(), 1'b0, 1'b0, 1'b0, 1'b1);
            end
            begin
                t = 0;
                do begin @(posedge clk); #1; t++; end while (!out_valid && t < 50);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        cnt_rdy_en = 1'b0;
        check("stall_in_ready_low", TW'(rdy_low), TW'(3));
        check("stall_out_count", TW'(out_log.size() - base), TW'(6));

        // 100 scrambled blocks with random sink backpressure
        do_reset();
        for (int n = 0; n < NL; n++) spos[n] = 0;
        plain_q.delete();
        base = out_log.size();
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 100; b++) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    p = rand_blk();
                    s = p;
                    if (kind >= 2) begin
                        for (int n = 0; n < NL; n++)
                            for (int i = 0; i < DW; i++) s[n*DW + i] ^= ks[n][spos[n] + i];
                    end
                    if (kind != 1)
                        for (int n = 0; n < NL; n++) spos[n] += DW;
                    plain_q.push_back(p);
                    send(s, kind == 0, kind == 1, 1'b0, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        for (int b = 0; b < 100; b++) check("plaintext", out_log[base+b], plain_q[b]);

        // Descramble disabled: bypass and frozen state
        base = out_log.size();
        plain_q.delete();
        for (int b = 0; b < 5; b++) begin
            p = rand_blk();
            plain_q.push_back(p);
            send(p, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send('0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        for (int b = 0; b < 5; b++) check("bypass", out_log[base+b], plain_q[b]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
